// File: rtl/gpi_pad_ctrl.sv
// gpi_pad_ctrl: per-pad input-enable sequencing, DI synchronisation,
// debounce and sticky edge interrupts for a bank of pulldown input pads.
module gpi_pad_ctrl #(
  parameter int unsigned NPADS       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_W       = 8,
  parameter int unsigned SETTLE_CYC  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NPADS-1:0]     en_i,
  input  logic [1:0]           ste_cfg_i,
  input  logic [DEB_W-1:0]     deb_len_i,
  input  logic [NPADS-1:0]     rise_en_i,
  input  logic [NPADS-1:0]     fall_en_i,
  input  logic [NPADS-1:0]     irq_clr_i,
  input  logic [2*NPADS-1:0]   pad_di_i,
  output logic [NPADS-1:0]     pad_ie_o,
  output logic [2*NPADS-1:0]   pad_ste_o,
  output logic [NPADS-1:0]     level_o,
  output logic [NPADS-1:0]     active_o,
  output logic [NPADS-1:0]     irq_pend_o,
  output logic                 irq_o
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_SETTLE = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  state_e                 state_q  [NPADS];
  state_e                 state_d  [NPADS];
  logic [SW-1:0]          settle_q [NPADS];
  logic [SW-1:0]          settle_d [NPADS];
  logic [DEB_W-1:0]       cnt_q    [NPADS];
  logic [DEB_W-1:0]       cnt_d    [NPADS];
  logic [SYNC_STAGES-1:0] sync_q   [NPADS];
  logic [SYNC_STAGES-1:0] sync_d   [NPADS];
  logic [NPADS-1:0]       level_q, level_d;
  logic [NPADS-1:0]       ie_q, ie_d;
  logic [NPADS-1:0]       act_q, act_d;
  logic [NPADS-1:0]       pend_q, pend_d;
  logic [2*NPADS-1:0]     ste_q, ste_d;
  logic [NPADS-1:0]       di_odd_unused;

  // Register all per-pad state; asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NPADS; k++) begin
        state_q[k]  <= S_OFF;
        settle_q[k] <= '0;
        cnt_q[k]    <= '0;
        sync_q[k]   <= '0;
      end
      level_q <= '0;
      ie_q    <= '0;
      act_q   <= '0;
      pend_q  <= '0;
      ste_q   <= '0;
    end else begin
      for (int unsigned k = 0; k < NPADS; k++) begin
        state_q[k]  <= state_d[k];
        settle_q[k] <= settle_d[k];
        cnt_q[k]    <= cnt_d[k];
        sync_q[k]   <= sync_d[k];
      end
      level_q <= level_d;
      ie_q    <= ie_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      ste_q   <= ste_d;
    end
  end

  // Per-pad FSM, synchroniser shift, debounce and interrupt next-state.
  always_comb begin
    level_d       = level_q;
    ste_d         = ste_q;
    ie_d          = '0;
    act_d         = '0;
    pend_d        = '0;
    di_odd_unused = '0;
    for (int unsigned k = 0; k < NPADS; k++) begin
      logic sync_v;
      logic set_v;
      state_d[k]  = state_q[k];
      settle_d[k] = settle_q[k];
      cnt_d[k]    = cnt_q[k];
      sync_d[k]   = {sync_q[k][SYNC_STAGES-2:0], pad_di_i[2*k]};
      di_odd_unused[k] = pad_di_i[2*k+1];
      sync_v      = sync_q[k][SYNC_STAGES-1];
      set_v       = 1'b0;

      if (!en_i[k]) begin
        // Disable from any state: drop level/count silently, keep pending.
        state_d[k] = S_OFF;
        level_d[k] = 1'b0;
        cnt_d[k]   = '0;
      end else begin
        case (state_q[k])
          S_OFF: begin
            state_d[k]       = S_SETTLE;
            settle_d[k]      = SETTLE_LOAD;
            ste_d[2*k +: 2]  = ste_cfg_i;
            level_d[k]       = 1'b0;
            cnt_d[k]         = '0;
          end
          S_SETTLE: begin
            if (settle_q[k] == '0) begin
              state_d[k] = S_ACTIVE;
              level_d[k] = sync_v;
            end else begin
              settle_d[k] = settle_q[k] - SW'(1);
            end
          end
          S_ACTIVE: begin
            if (sync_v == level_q[k]) begin
              cnt_d[k] = '0;
            end else if (cnt_q[k] >= deb_len_i) begin
              level_d[k] = sync_v;
              cnt_d[k]   = '0;
              set_v      = sync_v ? rise_en_i[k] : fall_en_i[k];
            end else begin
              cnt_d[k] = cnt_q[k] + DEB_W'(1);
            end
          end
          default: state_d[k] = S_OFF;
        endcase
      end

      ie_d[k]   = (state_d[k] != S_OFF);
      act_d[k]  = (state_d[k] == S_ACTIVE);
      pend_d[k] = (pend_q[k] & ~irq_clr_i[k]) | set_v;
    end
  end

  assign pad_ie_o   = ie_q;
  assign pad_ste_o  = ste_q;
  assign level_o    = level_q;
  assign active_o   = act_q;
  assign irq_pend_o = pend_q;
  assign irq_o      = |pend_q;

endmodule

// File: doc/gpi_pad_ctrl.md
Name: gpi_pad_ctrl

Overview:
Controller for a bank of NPADS general-purpose input pad cells with pulldown.
- Drives each pad's input-enable (IE) and Schmitt-trigger config (STE).
- Sequences a per-pad enable/settle/active state machine.
- Synchronises and debounces the pad's DI data.
- Produces edge-triggered, sticky interrupt flags.
Sits between the IO ring and the SoC GPIO/interrupt register block.

Parameters:
NPADS, 8, number of controlled pads
SYNC_STAGES, 2, synchroniser flops per pad (min 2)
DEB_W, 8, debounce counter / deb_len_i width
SETTLE_CYC, 4, cycles in SETTLE before ACTIVE (min 1)

Ports:
clk_i  in  1  block clock
rst_ni  in  1  reset, asynchronous, active-low
en_i  in  NPADS  per-pad enable level
ste_cfg_i  in  2  Schmitt config, captured per pad at enable
deb_len_i  in  DEB_W  debounce length in cycles (shared)
rise_en_i  in  NPADS  rising-edge interrupt enable
fall_en_i  in  NPADS  falling-edge interrupt enable
irq_clr_i  in  NPADS  one-cycle clear pulse per pending bit
pad_di_i  in  2*NPADS  pad DI_O pairs; bit 2k is data for pad k, bit 2k+1 ignored
pad_ie_o  out  NPADS  pad IE_I drive
pad_ste_o  out  2*NPADS  pad STE_I drive, bits [2k+1:2k] for pad k
level_o  out  NPADS  debounced pad level
active_o  out  NPADS  pad in ACTIVE state
irq_pend_o  out  NPADS  sticky edge flags
irq_o  out  1  OR of irq_pend_o

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - All FSMs in OFF.
  - Synchroniser, counter, level and ste registers 0.
- All outputs are driven from flops, except irq_o, which is the combinational OR of flops.

Per-pad FSM:
- OFF:
  - pad_ie_o=0, level=0, cnt=0.
  - If en_i=1, next state is SETTLE. On this transition, capture ste_cfg_i into ste[k] and load the settle counter with SETTLE_CYC-1.
- SETTLE:
  - pad_ie_o=1.
  - Settle counter decrements each cycle.
  - When it reaches 0 and en_i=1, go to ACTIVE. On that transition, load level with the synced value; no edge event is generated.
- ACTIVE:
  - pad_ie_o=1, active_o=1.
  - Debounce and edge detection are enabled.
- en_i=0 in any state:
  - Next state is OFF; pad_ie_o falls the next cycle.
  - level and cnt are forced to 0 with no edge event.
  - irq_pend is retained.
- pad_ste_o[k] = ste[k] at all times.
  - ste changes only on the OFF->SETTLE transition.
  - ste_cfg_i changes while a pad is SETTLE or ACTIVE have no effect.
- Timing: en_i rise at cycle t gives pad_ie_o=1 at t+1 and active_o=1 at t+1+SETTLE_CYC.

Synchroniser:
- pad_di_i[2k] passes through SYNC_STAGES flops to give sync[k].
- The synchroniser runs in all states. While IE=0 the pad returns 0.

Debounce (ACTIVE only):
- If sync == level: cnt <= 0.
- If sync != level and cnt >= deb_len_i: level <= sync, cnt <= 0.
  - The >= comparison handles deb_len_i being lowered mid-count.
- Otherwise: cnt <= cnt+1.
- A pad change that stays stable reaches level_o after SYNC_STAGES + deb_len_i + 1 cycles.
- A change shorter than deb_len_i+1 synced cycles is filtered.
- deb_len_i=0: no filtering, latency SYNC_STAGES+1.

Interrupts:
- Set irq_pend[k] on a level 0->1 update with rise_en_i[k]=1, or a level 1->0 update with fall_en_i[k]=1.
- Clear on irq_clr_i[k]=1.
- Set and clear in the same cycle: set wins, bit stays 1.
- irq_pend_o is updated the same cycle as level_o.
- Enable bits are sampled at the update cycle only. Enabling later does not raise a missed edge.

Test Plan:
- Reset: assert rst_ni=0 mid-run with pads ACTIVE and pending set -> all outputs 0 immediately (asynchronous), FSMs in OFF after release.
- Enable sequencing: ste_cfg_i=2'b10, en_i[0] rises at t with pad high -> pad_ie_o[0]=1 at t+1, pad_ste_o[1:0]=2'b10, active_o[0]=1 at t+5, level_o[0]=1, irq_pend_o=0. Changing ste_cfg_i afterwards leaves pad_ste_o at 2'b10.
- Debounce: deb_len_i=3, fall_en_i[0]=1.
  - 3-cycle low glitch -> level_o stays 1, no irq.
  - Sustained low from t -> level_o[0]=0 and irq_pend_o[0]=1, irq_o=1 at t+6.
- Clear race: irq_clr_i[0] pulsed in the same cycle as a new debounced rise with rise_en_i[0]=1 -> irq_pend_o[0] stays 1. A clear alone on the next cycle -> 0.
- Disable mid-count: deb_len_i=10, drop en_i[0] 5 cycles into a debounce -> pad_ie_o[0]=0, level_o[0]=0 next cycle, no irq. Re-enable -> full SETTLE_CYC settle again.
- Zero debounce, multi-pad: deb_len_i=0, pads 0 and 7 toggled the same cycle -> both level_o bits update after exactly 3 cycles, independent irq_pend bits.
